// File: rtl/sync_fifo_bram_if.sv
// sync_fifo_bram_if: write/read request, flush and status bundle for a single-clock FIFO.
//
// Handshake semantics, applying to both FIFO ports:
//   - A write transfers on a rising edge when wr_en && !full.
//   - A read transfers on a rising edge when rd_en && !empty. The word appears on
//     data_out with rd_valid high for exactly the following cycle.
//   - full and empty are the "ready" indications. They depend only on registered
//     state and never on the same-cycle wr_en/rd_en, so a requester may hold a
//     request high while waiting.
//   - A request made against full or empty is dropped and latched in overflow or
//     underflow. These flags stay set until clr or reset.
interface sync_fifo_bram_if #(
    parameter int WIDTH   = 8,
    parameter int PTR_LEN = 4
);
    logic               clr;
    logic               wr_en;
    logic [WIDTH-1:0]   data_in;
    logic               rd_en;
    logic [WIDTH-1:0]   data_out;
    logic               rd_valid;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [PTR_LEN:0]   level;
    logic               overflow;
    logic               underflow;

    // Producer/consumer side: issues requests and observes data and status.
    modport master (
        output clr, wr_en, data_in, rd_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    // FIFO side: accepts requests and drives data and status.
    modport slave (
        input  clr, wr_en, data_in, rd_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_bram.sv
// sync_fifo_bram: single-clock FIFO built around an inferred RAM array.
// It has a registered read port with a one-cycle valid strobe, an occupancy
// count, almost-full/almost-empty thresholds, sticky error flags and a
// synchronous flush.
//
// The pointers are PTR_LEN+1 bits wide. The low bits address the RAM and the
// MSB is the wrap bit, so a modular difference of the pointers gives the exact
// occupancy 0..DEPTH. All status is derived from the registered pointers only.
module sync_fifo_bram #(
    parameter int WIDTH      = 8,
    parameter int PTR_LEN    = 4,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_bram_if.slave    fifo
);

    localparam int DEPTH = 2 ** PTR_LEN;

    localparam logic [PTR_LEN:0] DEPTH_LVL  = (PTR_LEN + 1)'(DEPTH);
    localparam logic [PTR_LEN:0] AFULL_THR  = (PTR_LEN + 1)'(AFULL_LVL);
    localparam logic [PTR_LEN:0] AEMPTY_THR = (PTR_LEN + 1)'(AEMPTY_LVL);
    localparam logic [PTR_LEN:0] PTR_ZERO   = '0;
    localparam logic [PTR_LEN:0] PTR_ONE    = {{PTR_LEN{1'b0}}, 1'b1};

    // Storage. It is never reset or cleared: only the pointers define which
    // words are valid.
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic [PTR_LEN:0]   wr_ptr_q;
    logic [PTR_LEN:0]   wr_ptr_d;
    logic [PTR_LEN:0]   rd_ptr_q;
    logic [PTR_LEN:0]   rd_ptr_d;
    logic [WIDTH-1:0]   data_out_q;
    logic [WIDTH-1:0]   data_out_d;
    logic               rd_valid_q;
    logic               rd_valid_d;
    logic               overflow_q;
    logic               overflow_d;
    logic               underflow_q;
    logic               underflow_d;

    logic [PTR_LEN:0]   level;
    logic               full;
    logic               empty;
    logic               wr_accept;
    logic               rd_accept;
    logic [PTR_LEN-1:0] wr_addr;
    logic [PTR_LEN-1:0] rd_addr;

    // Occupancy and flags come purely from the registered pointers.
    always_comb begin
        level   = wr_ptr_q - rd_ptr_q;
        full    = (level == DEPTH_LVL);
        empty   = (level == PTR_ZERO);
        wr_addr = wr_ptr_q[PTR_LEN-1:0];
        rd_addr = rd_ptr_q[PTR_LEN-1:0];
    end

    // Request acceptance.
    // full is sampled before this cycle's read, so a write is never accepted
    // while full, even when a read is accepted in the same cycle. A flush
    // masks both requests.
    always_comb begin
        wr_accept = fifo.wr_en && !full  && !fifo.clr;
        rd_accept = fifo.rd_en && !empty && !fifo.clr;
    end

    // Next-state logic for the pointers, the read port and the sticky error
    // flags. A flush takes priority over everything except reset.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (fifo.clr) begin
            wr_ptr_d    = PTR_ZERO;
            rd_ptr_d    = PTR_ZERO;
            data_out_d  = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else if (fifo.wr_en) begin
                overflow_d = 1'b1;
            end

            // data_out holds its previous word when no read is accepted.
            if (rd_accept) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = mem_q[rd_addr];
                rd_valid_d = 1'b1;
            end else if (fifo.rd_en) begin
                underflow_d = 1'b1;
            end
        end
    end

    // RAM write port. It has no reset, which keeps the array inferable as block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_addr] <= fifo.data_in;
        end
    end

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Drive the interface outputs.
    always_comb begin
        fifo.data_out     = data_out_q;
        fifo.rd_valid     = rd_valid_q;
        fifo.full         = full;
        fifo.empty        = empty;
        fifo.almost_full  = (level >= AFULL_THR);
        fifo.almost_empty = (level <= AEMPTY_THR);
        fifo.level        = level;
        fifo.overflow     = overflow_q;
        fifo.underflow    = underflow_q;
    end

endmodule

// File: tb/tb_sync_fifo_bram.sv
// tb_sync_fifo_bram: directed vectors for sync_fifo_bram with default parameters.
// The stimulus side pushes each expected read word into exp_q as the read is
// issued. A separate monitor pops exp_q and compares on every rd_valid.
module tb_sync_fifo_bram;

    localparam int WIDTH   = 8;
    localparam int PTR_LEN = 4;
    localparam int DEPTH   = 16;
    localparam int AFULL   = 14;
    localparam int AEMPTY  = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_bram_if #(.WIDTH(WIDTH), .PTR_LEN(PTR_LEN)) bus ();

    sync_fifo_bram #(
        .WIDTH      (WIDTH),
        .PTR_LEN    (PTR_LEN),
        .AFULL_LVL  (AFULL),
        .AEMPTY_LVL (AEMPTY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fifo  (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mdl_q[$];
    logic             mdl_ovf;
    logic             mdl_udf;
    logic             mdl_rv;
    logic [WIDTH-1:0] mon_exp;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Compare the flags against the occupancy model after every cycle.
    task automatic check_model();
        int n;
        n = mdl_q.size();
        chk("level",        int'(bus.level),        n);
        chk("full",         int'(bus.full),         int'(n == DEPTH));
        chk("empty",        int'(bus.empty),        int'(n == 0));
        chk("almost_full",  int'(bus.almost_full),  int'(n >= AFULL));
        chk("almost_empty", int'(bus.almost_empty), int'(n <= AEMPTY));
        chk("overflow",     int'(bus.overflow),     int'(mdl_ovf));
        chk("underflow",    int'(bus.underflow),    int'(mdl_udf));
        chk("rd_valid",     int'(bus.rd_valid),     int'(mdl_rv));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_data_out"},     int'(bus.data_out),     0);
        chk({tag, "_rd_valid"},     int'(bus.rd_valid),     0);
        chk({tag, "_level"},        int'(bus.level),        0);
        chk({tag, "_empty"},        int'(bus.empty),        1);
        chk({tag, "_full"},         int'(bus.full),         0);
        chk({tag, "_almost_empty"}, int'(bus.almost_empty), 1);
        chk({tag, "_almost_full"},  int'(bus.almost_full),  0);
        chk({tag, "_overflow"},     int'(bus.overflow),     0);
        chk({tag, "_underflow"},    int'(bus.underflow),    0);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1. Drives one cycle of requests, updates the model, and
    // returns at posedge+1 after the edge that consumed them.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
        logic wa;
        logic ra;
        bus.wr_en   = w;
        bus.data_in = d;
        bus.rd_en   = r;
        bus.clr     = c;
        wa = w && !c && (mdl_q.size() < DEPTH);
        ra = r && !c && (mdl_q.size() > 0);
        if (c) begin
            mdl_q.delete();
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
        end else begin
            if (w && !wa) mdl_ovf = 1'b1;
            if (r && !ra) mdl_udf = 1'b1;
            if (ra) exp_q.push_back(mdl_q.pop_front());
            if (wa) mdl_q.push_back(d);
        end
        mdl_rv = ra;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr   = 1'b0;
        check_model();
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_spurious: got data 0x%0h expected no rd_valid", bus.data_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("rd_data", int'(bus.data_out), int'(mon_exp));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.clr     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        mdl_ovf     = 1'b0;
        mdl_udf     = 1'b0;
        mdl_rv      = 1'b0;

        // Power-on reset.
        #3;
        check_reset("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Preload three words and read one, so data_out becomes nonzero.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_level", int'(bus.level), 2);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        chk("pre_rst_data_out", int'(bus.data_out), 8'h11);

        // Assert reset in the middle of a write burst, between clock edges.
        bus.wr_en   = 1'b1;
        bus.data_in = 8'h55;
        #2 rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        bus.wr_en = 1'b0;
        mdl_q.delete();
        mdl_ovf = 1'b0;
        mdl_udf = 1'b0;
        mdl_rv  = 1'b0;
        chk("exp_q_idle_at_rst", exp_q.size(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill with 0x00..0x0F and check the almost_full / full boundaries.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 12) chk("afull_after_13", int'(bus.almost_full), 0);
            if (i == 13) chk("afull_after_14", int'(bus.almost_full), 1);
        end
        chk("full_after_16", int'(bus.full), 1);
        chk("level_after_16", int'(bus.level), 16);

        // The 17th write is rejected and sets overflow.
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_17th", int'(bus.overflow), 1);
        chk("level_17th", int'(bus.level), 16);

        // Drain all 16 words.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_after_drain", int'(bus.empty), 1);
        chk("drain_last_data", int'(bus.data_out), 8'h0F);

        // A read on empty is rejected: rd_valid stays low and data_out holds.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_rd_valid", int'(bus.rd_valid), 0);
        chk("udf_data_hold", int'(bus.data_out), 8'h0F);
        chk("udf_flag", int'(bus.underflow), 1);

        // Read and write together on empty: only the write is accepted.
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("rw_empty_level", int'(bus.level), 1);
        chk("rw_empty_udf", int'(bus.underflow), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rw_empty_next_data", int'(bus.data_out), 8'h5A);
        chk("rw_empty_next_valid", int'(bus.rd_valid), 1);

        // Clear the error flags before the wrap rounds.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr1_ovf", int'(bus.overflow), 0);
        chk("clr1_data_out", int'(bus.data_out), 0);

        // Three rounds of 10 writes and 10 reads, wrapping the pointers.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) step(1'b1, 8'(48 + r * 16 + i), 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_level", int'(bus.level), 0);
            chk("wrap_ovf", int'(bus.overflow), 0);
            chk("wrap_udf", int'(bus.underflow), 0);
        end

        // Simultaneous read and write at level 5 holds the level.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(96 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(112 + i), 1'b1, 1'b0);
            chk("sim_level5", int'(bus.level), 5);
        end

        // Fill to full, then read and write together: the write is rejected.
        for (int i = 0; i < 11; i++) step(1'b1, 8'(192 + i), 1'b0, 1'b0);
        chk("sim_full", int'(bus.full), 1);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("sim_full_level", int'(bus.level), 15);
        chk("sim_full_ovf", int'(bus.overflow), 1);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("sim_full_drained", int'(bus.empty), 1);

        // Flush at level 7 with overflow still set, with both requests high.
        for (int i = 0; i < 7; i++) step(1'b1, 8'(208 + i), 1'b0, 1'b0);
        chk("pre_flush_level", int'(bus.level), 7);
        chk("pre_flush_ovf", int'(bus.overflow), 1);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        chk("flush_level", int'(bus.level), 0);
        chk("flush_empty", int'(bus.empty), 1);
        chk("flush_ovf", int'(bus.overflow), 0);
        chk("flush_udf", int'(bus.underflow), 0);
        chk("flush_rd_valid", int'(bus.rd_valid), 0);
        chk("flush_data_out", int'(bus.data_out), 0);

        // Normal operation resumes after the flush.
        step(1'b1, 8'h99, 1'b0, 1'b0);
        chk("post_flush_level", int'(bus.level), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_flush_data", int'(bus.data_out), 8'h99);

        // Idle cycles, then confirm that every expected word was seen.
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_bram.md
# sync_fifo_bram

Single-clock, parametrised FIFO built around an inferred register/BRAM array; the single-clock successor to the dual-clock FIFO storage used on the MAC datapath. It adds a registered read port with a valid strobe, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between MAC-side producers and consumers that share one clock domain (e.g. TX frame staging ahead of the CRC/serialiser).

## Interface
- WIDTH, 8, data word width in bits
- PTR_LEN, 4, address width; DEPTH = 2**PTR_LEN words (PTR_LEN >= 2)
- AFULL_LVL, 14, almost_full asserted when level >= AFULL_LVL (1..2**PTR_LEN)
- AEMPTY_LVL, 2, almost_empty asserted when level <= AEMPTY_LVL (0..2**PTR_LEN-1)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush, highest priority after reset
- wr_en  in  1  write request
- data_in  in  WIDTH  write data
- rd_en  in  1  read request
- data_out  out  WIDTH  registered read data
- rd_valid  out  1  data_out updated by an accepted read this cycle
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AFULL_LVL
- almost_empty  out  1  level <= AEMPTY_LVL
- level  out  PTR_LEN+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write request rejected
- underflow  out  1  sticky: read request rejected

## Operation
- Pointers wr_ptr, rd_ptr are PTR_LEN+1 bits; low PTR_LEN bits address memory, MSB is the wrap bit. level = wr_ptr - rd_ptr modulo 2**(PTR_LEN+1).
- full/empty/almost flags and level are combinational from registered pointers only; no path from wr_en/rd_en to any flag.
- Write accepted iff wr_en && !full (full sampled this cycle; no write-through when full even if a read is accepted the same cycle). Accepted write: mem[wr_ptr low] <= data_in, wr_ptr++.
- Read accepted iff rd_en && !empty. Accepted read: data_out <= mem[rd_ptr low], rd_ptr++, rd_valid <= 1. Otherwise rd_valid <= 0, data_out holds previous value (no zero gating).
- Rejected write sets overflow; rejected read sets underflow; both stay set until clr or reset.
- Simultaneous accepted read and write: both pointers advance, level unchanged. At full: read accepted, write rejected, overflow set. At empty: write accepted, read rejected, underflow set; the new word is not readable until the following cycle.
- clr: pointers <= 0, rd_valid <= 0, data_out <= 0, overflow/underflow <= 0; wr_en/rd_en in that cycle ignored and do not set error flags.
- Memory contents are not reset or cleared; only pointers define validity.
- Reset (rst_n low, immediate, no clock needed): data_out 0, rd_valid 0, level 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.

## Timing
- Write-to-flag latency: 1 cycle (flags reflect a write on the edge after it is accepted).
- Read latency: 1 cycle; data_out and rd_valid valid in the cycle after the accepted rd_en edge, rd_valid high for exactly one cycle per accepted read.
- Write-to-read latency on empty FIFO: word written at edge N readable with rd_en at edge N+1, data_out valid after edge N+1.
- Sustained throughput: one write and one read per cycle at any level 1..DEPTH-1.
- rst_n deassertion is released synchronously by the system; first accepted operation on the first edge with rst_n high.

## Test plan
- Reset: assert rst_n low mid-burst with no clock -> all outputs at reset values immediately; level 0, empty 1.
- Fill/drain (defaults): write 0x00..0x0F -> almost_full after 14th write, full and level 16 after 16th; 17th write 0xAA -> rejected, overflow 1; read 16 -> data_out 0x00..0x0F, each with rd_valid 1 cycle after rd_en, empty after last.
- Wrap: 3 rounds of 10 writes then 10 reads -> order preserved across pointer wrap, level returns to 0, no error flags.
- Simultaneous: at level 5, rd_en+wr_en for 20 cycles -> level stays 5, output sequence in order; at full, rd_en+wr_en -> level 15, overflow 1, rejected word never appears.
- Underflow: rd_en on empty -> rd_valid 0, data_out unchanged, underflow 1; rd_en+wr_en on empty -> level 1, underflow 1, next rd_en returns written word.
- Flush: at level 7 with overflow set, clr with wr_en and rd_en high -> level 0, empty 1, overflow/underflow 0, rd_valid 0, data_out 0; next write/read behaves normally.
